// File: rtl/load_store_pkg.sv
// Shared types and default sizing for the load/store fill loop (filler and unloader).
package load_store_pkg;

  localparam int unsigned LS_N     = 15000;
  localparam int unsigned LS_CBITS = 14;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PAUSE,
    DONE,
    WAIT_LOW
  } drain_state_t;

endpackage

// File: rtl/burst_pacer.sv
// Burst/gap pacing for the drain unloader: counts transfers per burst and the idle gap after it.
module burst_pacer #(
  parameter int unsigned BURST = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic xfer,
  output logic pause_req,
  output logic gap_done
);

  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);

  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic          at_max;

  assign at_max    = (burst_cnt == BURST_MAX);
  assign pause_req = xfer && at_max && (GAP > 0);
  assign gap_done  = (gap_cnt == GW'(1));

  // Wraps at BURST-1 whether or not a pause follows.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= at_max ? '0 : burst_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      gap_cnt <= '0;
    end else if (pause_req) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: rtl/drain_unloader.sv
// Consumer end of the fill loop: takes a full tank of N units and unloads it with paced bursts.
// Optional SVA checks compile in when DRAIN_UNLOADER_PROPS_EN is defined.
module drain_unloader
  import load_store_pkg::*;
#(
  parameter int unsigned N     = LS_N,
  parameter int unsigned CBITS = LS_CBITS,
  parameter int unsigned BURST = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [CBITS-1:0] level,
  output logic             busy,
  output logic             empty_out,
  output logic             overrun
);

  localparam logic [CBITS-1:0] LEVEL_FULL = CBITS'(N);

  drain_state_t state, state_next;
  logic         full_d1;
  logic         xfer;
  logic         load;
  logic         pause_req;
  logic         gap_done;

  assign xfer = out_valid & out_ready;
  assign load = (state == IDLE) & full_in;

  burst_pacer #(
    .BURST(BURST),
    .GAP  (GAP)
  ) u_pacer (
    .clk      (clk),
    .rst      (rst),
    .start    (load),
    .xfer     (xfer),
    .pause_req(pause_req),
    .gap_done (gap_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (full_in) state_next = DRAIN;
      DRAIN: begin
        if (xfer) begin
          if (level == CBITS'(1)) begin
            state_next = DONE;
          end else if (pause_req) begin
            state_next = PAUSE;
          end
        end
      end
      PAUSE:    if (gap_done) state_next = DRAIN;
      DONE:     state_next = WAIT_LOW;
      WAIT_LOW: if (!full_in) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && (level == CBITS'(1));
    busy      = (state == DRAIN) || (state == PAUSE);
    empty_out = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else if (load) begin
      level <= LEVEL_FULL;
    end else if (xfer && (level != '0)) begin
      level <= level - CBITS'(1);
    end
  end

  // Only a fresh rising edge of full_in counts; a level held since the load is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_d1 <= 1'b0;
      overrun <= 1'b0;
    end else begin
      full_d1 <= full_in;
      if (busy && full_in && !full_d1) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef DRAIN_UNLOADER_PROPS_EN
  a_level_max: assert property (@(posedge clk) disable iff (rst) level <= LEVEL_FULL);
  a_valid_hold: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable(level));
  a_empty_pulse: assert property (@(posedge clk) disable iff (rst) empty_out |=> !empty_out);
  m_no_rst: assume property (@(posedge clk) !rst);
  m_ready_live: assume property (@(posedge clk) s_eventually out_ready);
  a_drain_live: assert property (@(posedge clk) busy |-> s_eventually empty_out);
  c_empty: cover property (@(posedge clk) empty_out);
`else
  // Default build carries no properties.
`endif

endmodule

// File: tb/tb_drain_unloader.sv
// Scoreboard bench for drain_unloader: N=20/BURST=4/GAP=2 instance plus an N=1/GAP=0 instance.
module tb_drain_unloader;

  typedef struct {
    int lvl;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        full_in = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, busy, empty_out, overrun;
  logic [13:0] level;

  logic        full1 = 1'b0;
  logic        ready1 = 1'b0;
  logic        valid1, last1, busy1, empty1, overrun1;
  logic [13:0] level1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  drain_unloader #(.N(20), .CBITS(14), .BURST(4), .GAP(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .full_in  (full_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_last (out_last),
    .level    (level),
    .busy     (busy),
    .empty_out(empty_out),
    .overrun  (overrun)
  );

  drain_unloader #(.N(1), .CBITS(14), .BURST(4), .GAP(0)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .full_in  (full1),
    .out_ready(ready1),
    .out_valid(valid1),
    .out_last (last1),
    .level    (level1),
    .busy     (busy1),
    .empty_out(empty1),
    .overrun  (overrun1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tank(input int n);
    for (int i = n; i >= 1; i--) sb.push_back('{lvl: i, last: (i == 1)});
  endtask

  // Load a tank on dut: full_in high for one edge; optionally leave it high.
  task automatic load_tank(input bit keep_high);
    full_in = 1'b1;
    push_tank(20);
    step();
    if (!keep_high) full_in = 1'b0;
    check("load_valid", out_valid, 1);
    check("load_level", level, 20);
    check("load_busy", busy, 1);
  endtask

  // mode 0: ready always high; mode 1: ready toggles. glitch >= 0 pulses full_in low then high.
  task automatic run_drain(input int mode, input int glitch, output int xfers);
    int  gap_len = 0;
    bit  hold_pending = 0;
    int  hold_level = 0;
    bit  done = 0;
    bit  rdy;
    exp_t e;
    xfers = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (c == glitch) full_in = 1'b0;
      if (c == glitch + 1) full_in = 1'b1;
      if (c == glitch + 2) full_in = 1'b0;
      rdy = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      out_ready = rdy;
      if (hold_pending) begin
        check("valid_hold", out_valid, 1);
        check("level_hold", level, hold_level);
        hold_pending = 0;
      end
      if (out_valid) begin
        if (gap_len > 0) begin
          check("gap_len", gap_len, 2);
          check("gap_pos", xfers % 4, 0);
          gap_len = 0;
        end
        if (rdy) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("xfer_level", level, e.lvl);
            check("xfer_last", out_last, e.last);
          end
          xfers++;
        end else begin
          hold_pending = 1;
          hold_level = level;
        end
      end else if (busy) begin
        gap_len++;
      end
      if (empty_out) begin
        check("empty_sb", sb.size(), 0);
        check("empty_level", level, 0);
        check("empty_busy", busy, 0);
        done = 1;
      end
      step();
    end
    out_ready = 1'b0;
    if (!done) check("drain_timeout", 0, 1);
    check("empty_single", empty_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nx;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", empty_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    step();

    // Straight drain with ready high.
    out_ready = 1'b1;
    load_tank(0);
    run_drain(0, -1, nx);
    check("t1_xfers", nx, 20);
    check("t1_overrun", overrun, 0);

    // Toggling ready.
    step();
    load_tank(0);
    run_drain(1, -1, nx);
    check("t2_xfers", nx, 20);

    // full_in held high: one drain, then parked without reload.
    step();
    load_tank(1);
    run_drain(0, -1, nx);
    check("t3_xfers", nx, 20);
    for (int i = 0; i < 5; i++) begin
      check("park_busy", busy, 0);
      check("park_valid", valid1 | out_valid, 0);
      check("park_level", level, 0);
      step();
    end
    full_in = 1'b0;
    step();
    check("t3_overrun", overrun, 0);

    // Re-arm, then a low/high glitch mid-drain sets overrun.
    load_tank(1);
    run_drain(0, 2, nx);
    check("t4_xfers", nx, 20);
    check("t4_overrun", overrun, 1);
    step();
    check("t4_overrun_sticky", overrun, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_overrun_clr", overrun, 0);
    step();

    // Reset mid-drain at level 7.
    out_ready = 1'b1;
    load_tank(0);
    for (int c = 0; c < 100 && level != 14'd7; c++) step();
    check("t5_lvl7", level, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    check("t5_valid", out_valid, 0);
    check("t5_level", level, 0);
    check("t5_busy", busy, 0);
    check("t5_empty", empty_out, 0);
    check("t5_last", out_last, 0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_empty", empty_out, 0);
      step();
    end

    // N=1, GAP=0 instance.
    full1 = 1'b1;
    step();
    full1 = 1'b0;
    check("n1_valid", valid1, 1);
    check("n1_last", last1, 1);
    check("n1_level", level1, 1);
    step();
    check("n1_hold_valid", valid1, 1);
    check("n1_hold_busy", busy1, 1);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    check("n1_empty", empty1, 1);
    check("n1_done_valid", valid1, 0);
    check("n1_done_level", level1, 0);
    check("n1_done_busy", busy1, 0);
    step();
    check("n1_empty_single", empty1, 0);
    check("n1_idle_busy", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
